instr_fetch_stage: RTL and testbench
====================================

Name: instr_fetch_stage

Overview:
- Fetch stage directly upstream of the decode/control stage.
- Owns the PC and issues one outstanding instruction-memory read at a time, with variable latency.
- Buffers the returned word in the IF/ID output register with a valid/ready handshake.
- Exposes opcode = instr[31:26] to the control unit.
- Accepts a single redirect (taken branch / jump) from downstream, flushes the wrong-path instruction and drops any in-flight response.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset; must be word-aligned.
- ADDR_W, 32, PC and instruction-memory address width.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  synchronous reset, active-low.
- imem_req  out  1  one-cycle read request pulse.
- imem_addr  out  ADDR_W  read address; valid while imem_req=1.
- imem_rdata  in  32  instruction word; valid while imem_rvalid=1.
- imem_rvalid  in  1  response strobe: exactly one per request, latency >=1 cycle.
- redirect_valid  in  1  one-cycle pulse: branch taken or jump.
- redirect_pc  in  ADDR_W  new fetch address; bits [1:0] are forced to 0 internally.
- out_valid  out  1  IF/ID register holds a valid instruction.
- out_ready  in  1  decode accepts the instruction this cycle.
- out_instr  out  32  fetched instruction.
- out_pc_plus4  out  ADDR_W  address of out_instr + 4.
- opcode  out  6  out_instr[31:26]; feeds the control unit.

Behaviour:
- Reset (rst_n=0 at a clock edge):
  - pc=RESET_PC, state=IDLE, imem_req=0, out_valid=0.
  - out_instr=32'h0 (NOP), out_pc_plus4=0, hold buffer empty, discard flag clear.
  - Reset mid-transaction abandons it; a late imem_rvalid arriving while in IDLE is ignored.
- FSM states: IDLE, ISSUE, WAIT, HOLD.
  - IDLE: next cycle go to ISSUE.
  - ISSUE: imem_req=1, imem_addr=pc; go to WAIT.
  - WAIT: on imem_rvalid:
    - If the discard flag is set: drop the data, clear the flag, go to ISSUE.
    - Else if the output slot is free (out_valid=0 or out_ready=1): load out_instr=imem_rdata and out_pc_plus4=pc+4, set out_valid=1, pc<=pc+4, go to ISSUE.
    - Else: capture into the hold buffer, pc<=pc+4, go to HOLD.
  - HOLD: when out_ready=1, move the hold buffer into the output register (out_valid stays 1), go to ISSUE.
- Output handshake:
  - Transfer occurs on out_valid & out_ready.
  - out_valid with no transfer: all out_* outputs stay stable.
  - Transfer with no new word: out_valid<=0.
- Latency and throughput:
  - With memory latency L: request at t, rvalid at t+L, out_valid at t+L+1.
  - Sustained rate is one instruction per L+1 cycles.
- Redirect (highest priority, overrides all of the above in the same cycle):
  - pc<=redirect_pc & ~3; out_valid<=0; hold buffer cleared.
  - IDLE or HOLD: go to ISSUE.
  - ISSUE: the request goes out with the old pc; set the discard flag; go to WAIT.
  - WAIT without rvalid: set the discard flag; stay in WAIT.
  - WAIT with rvalid in the same cycle: drop the data; go to ISSUE.
  - Coincident out_ready: the flush wins, but decode still consumes that cycle's word. Decode is responsible for ignoring it (it is the delay-slot-free wrong path).
- Arithmetic:
  - pc+4 wraps modulo 2^ADDR_W without error.
  - imem_rvalid outside WAIT is a protocol violation and is ignored (the bench asserts it never happens).
- imem_req is never high in two consecutive cycles.

Decomposition:
- Shared package mips_pkg holds:
  - opcode constants (R-type 6'h00, ADDI 6'h08, BEQ 6'h04, J 6'h02, LW 6'h23, SW 6'h2B);
  - NOP word 32'h0;
  - fetch FSM state encoding (2-bit);
  - default RESET_PC.
- One natural sub-module: fetch_out_buffer, containing the output register plus the one-entry hold buffer, the valid/ready logic and the flush input.

Test Plan:
- Reset release, RESET_PC=0, L=1, out_ready=1 -> imem_addr sequence 0x0, 0x4, 0x8; out_pc_plus4 sequence 0x4, 0x8, 0xC; out_valid first high 3 cycles after rst_n rises.
- L=1, out_ready held 0 after the first word (0x2002_0005) -> second word goes to HOLD; out_instr stays 0x2002_0005 with no new imem_req. Raising out_ready -> second word presented next cycle, then fetch resumes at 0x8.
- Redirect to 0x0000_0103 while in WAIT with L=3 -> the response at the old pc is dropped; the next imem_addr is 0x0000_0100; out_valid=0 until that word returns.
- redirect_valid coincident with imem_rvalid -> the word is not presented; the next request is to redirect_pc the following cycle.
- pc=0xFFFF_FFFC fetched -> out_pc_plus4=0x0000_0000 and the next imem_addr is 0x0.
- rst_n=0 asserted in WAIT, then a late imem_rvalid arrives -> all outputs at reset values; no instruction presented; fetch restarts at RESET_PC.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS-style pipeline front end.
// Holds opcode constants, the NOP word, the fetch FSM encoding and the default reset PC.
package mips_pkg;

   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_ADDI  = 6'h08;
   localparam logic [5:0] OP_BEQ   = 6'h04;
   localparam logic [5:0] OP_J     = 6'h02;
   localparam logic [5:0] OP_LW    = 6'h23;
   localparam logic [5:0] OP_SW    = 6'h2B;

   localparam logic [31:0] NOP_WORD         = 32'h0000_0000;
   localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

   typedef enum logic [1:0] {
      FS_IDLE  = 2'd0,
      FS_ISSUE = 2'd1,
      FS_WAIT  = 2'd2,
      FS_HOLD  = 2'd3
   } fetch_state_e;

   function automatic logic [5:0] opcode_of(input logic [31:0] instr);
      return instr[31:26];
   endfunction

endpackage

// File: rtl/fetch_out_buffer.sv
// IF/ID output register plus a one-entry hold buffer for a word that returns
// while decode is stalled; flush empties both.
module fetch_out_buffer
   import mips_pkg::*;
#(
   parameter int unsigned ADDR_W = 32
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              flush,
   input  logic              load_out,
   input  logic              load_hold,
   input  logic              move_hold,
   input  logic [31:0]       word,
   input  logic [ADDR_W-1:0] word_pc_plus4,
   input  logic              out_ready,
   output logic              out_valid,
   output logic [31:0]       out_instr,
   output logic [ADDR_W-1:0] out_pc_plus4
);

   logic              out_valid_q, out_valid_d;
   logic [31:0]       out_instr_q, out_instr_d;
   logic [ADDR_W-1:0] out_pc4_q, out_pc4_d;
   logic              hold_valid_q, hold_valid_d;
   logic [31:0]       hold_instr_q, hold_instr_d;
   logic [ADDR_W-1:0] hold_pc4_q, hold_pc4_d;

   always_comb begin
      out_valid_d  = out_valid_q;
      out_instr_d  = out_instr_q;
      out_pc4_d    = out_pc4_q;
      hold_valid_d = hold_valid_q;
      hold_instr_d = hold_instr_q;
      hold_pc4_d   = hold_pc4_q;
      if (flush) begin
         out_valid_d  = 1'b0;
         hold_valid_d = 1'b0;
      end else if (load_out) begin
         out_valid_d = 1'b1;
         out_instr_d = word;
         out_pc4_d   = word_pc_plus4;
      end else if (move_hold && hold_valid_q) begin
         // out_valid stays high: the held word replaces the one decode just took
         out_valid_d  = 1'b1;
         out_instr_d  = hold_instr_q;
         out_pc4_d    = hold_pc4_q;
         hold_valid_d = 1'b0;
      end else begin
         if (load_hold) begin
            hold_valid_d = 1'b1;
            hold_instr_d = word;
            hold_pc4_d   = word_pc_plus4;
         end
         if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         out_valid_q  <= 1'b0;
         out_instr_q  <= NOP_WORD;
         out_pc4_q    <= '0;
         hold_valid_q <= 1'b0;
         hold_instr_q <= NOP_WORD;
         hold_pc4_q   <= '0;
      end else begin
         out_valid_q  <= out_valid_d;
         out_instr_q  <= out_instr_d;
         out_pc4_q    <= out_pc4_d;
         hold_valid_q <= hold_valid_d;
         hold_instr_q <= hold_instr_d;
         hold_pc4_q   <= hold_pc4_d;
      end
   end

   assign out_valid    = out_valid_q;
   assign out_instr    = out_instr_q;
   assign out_pc_plus4 = out_pc4_q;

endmodule

// File: rtl/instr_fetch_stage.sv
// Instruction fetch stage: owns the PC, keeps one imem read in flight and hands
// returned words to decode; a redirect flushes the wrong path and drops in-flight data.
module instr_fetch_stage
   import mips_pkg::*;
#(
   parameter int unsigned       ADDR_W   = 32,
   parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(DEFAULT_RESET_PC)
) (
   input  logic              clk,
   input  logic              rst_n,
   output logic              imem_req,
   output logic [ADDR_W-1:0] imem_addr,
   input  logic [31:0]       imem_rdata,
   input  logic              imem_rvalid,
   input  logic              redirect_valid,
   input  logic [ADDR_W-1:0] redirect_pc,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [31:0]       out_instr,
   output logic [ADDR_W-1:0] out_pc_plus4,
   output logic [5:0]        opcode
);

   fetch_state_e      state_q;
   logic [ADDR_W-1:0] pc_q;
   logic              discard_q;
   logic              req_q;

   logic [ADDR_W-1:0] pc_plus4;
   logic [ADDR_W-1:0] redirect_aligned;
   logic              slot_free;
   logic              rsp_live;
   logic              load_out;
   logic              load_hold;
   logic              move_hold;

   assign pc_plus4         = pc_q + ADDR_W'(4);
   assign redirect_aligned = redirect_pc & ~ADDR_W'(3);
   assign slot_free        = !out_valid || out_ready;
   // A response is only kept if it is for the current path and no redirect kills it now
   assign rsp_live  = (state_q == FS_WAIT) && imem_rvalid && !discard_q && !redirect_valid;
   assign load_out  = rsp_live && slot_free;
   assign load_hold = rsp_live && !slot_free;
   assign move_hold = (state_q == FS_HOLD) && out_ready && !redirect_valid;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q   <= FS_IDLE;
         pc_q      <= RESET_PC;
         discard_q <= 1'b0;
         req_q     <= 1'b0;
      end else begin
         req_q <= 1'b0;
         if (redirect_valid) begin
            pc_q <= redirect_aligned;
            case (state_q)
               FS_ISSUE: begin
                  state_q   <= FS_WAIT;
                  discard_q <= 1'b1;
               end
               FS_WAIT: begin
                  if (imem_rvalid) begin
                     state_q   <= FS_ISSUE;
                     discard_q <= 1'b0;
                     req_q     <= 1'b1;
                  end else begin
                     discard_q <= 1'b1;
                  end
               end
               default: begin
                  state_q <= FS_ISSUE;
                  req_q   <= 1'b1;
               end
            endcase
         end else begin
            case (state_q)
               FS_IDLE: begin
                  state_q <= FS_ISSUE;
                  req_q   <= 1'b1;
               end
               FS_ISSUE: begin
                  state_q <= FS_WAIT;
               end
               FS_WAIT: begin
                  if (imem_rvalid) begin
                     if (discard_q) begin
                        discard_q <= 1'b0;
                        state_q   <= FS_ISSUE;
                        req_q     <= 1'b1;
                     end else begin
                        pc_q <= pc_plus4;
                        if (slot_free) begin
                           state_q <= FS_ISSUE;
                           req_q   <= 1'b1;
                        end else begin
                           state_q <= FS_HOLD;
                        end
                     end
                  end
               end
               FS_HOLD: begin
                  if (out_ready) begin
                     state_q <= FS_ISSUE;
                     req_q   <= 1'b1;
                  end
               end
               default: begin
                  state_q <= FS_IDLE;
               end
            endcase
         end
      end
   end

   assign imem_req  = req_q;
   assign imem_addr = pc_q;

   fetch_out_buffer #(
      .ADDR_W (ADDR_W)
   ) u_out_buffer (
      .clk           (clk),
      .rst_n         (rst_n),
      .flush         (redirect_valid),
      .load_out      (load_out),
      .load_hold     (load_hold),
      .move_hold     (move_hold),
      .word          (imem_rdata),
      .word_pc_plus4 (pc_plus4),
      .out_ready     (out_ready),
      .out_valid     (out_valid),
      .out_instr     (out_instr),
      .out_pc_plus4  (out_pc_plus4)
   );

   assign opcode = opcode_of(out_instr);

endmodule

// File: tb/tb_instr_fetch_stage.sv
// Bench for instr_fetch_stage: variable-latency memory model, directed timing cases
// and a random phase checked by a program-order scoreboard.
module tb_instr_fetch_stage;
   import mips_pkg::*;

   typedef struct packed {
      logic [31:0] instr;
      logic [31:0] pc4;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic [31:0] imem_rdata;
   logic        imem_rvalid;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_instr;
   logic [31:0] out_pc_plus4;
   logic [5:0]  opcode;

   int checks = 0;
   int errors = 0;
   int xfers  = 0;
   int lat_cfg = 1;
   bit lat_rand = 1'b0;
   exp_t exp_q[$];

   instr_fetch_stage #(
      .ADDR_W   (32),
      .RESET_PC (32'h0000_0000)
   ) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .imem_req       (imem_req),
      .imem_addr      (imem_addr),
      .imem_rdata     (imem_rdata),
      .imem_rvalid    (imem_rvalid),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .out_valid      (out_valid),
      .out_ready      (out_ready),
      .out_instr      (out_instr),
      .out_pc_plus4   (out_pc_plus4),
      .opcode         (opcode)
   );

   always #5 clk = ~clk;

   // Memory image: address 0 holds ADDI 0x2002_0005, others a mix of opcodes tagged by address
   function automatic logic [31:0] word_at(input logic [31:0] a);
      logic [5:0] op;
      int unsigned idx;
      if (a == 32'h0) return 32'h2002_0005;
      idx = (a >> 2) % 32'd6;
      case (idx)
         0: op = OP_RTYPE;
         1: op = OP_ADDI;
         2: op = OP_BEQ;
         3: op = OP_J;
         4: op = OP_LW;
         default: op = OP_SW;
      endcase
      return {op, a[27:2] ^ 26'h15A_5A5A};
   endfunction

   function automatic exp_t entry_at(input logic [31:0] a);
      exp_t e;
      e.instr = word_at(a);
      e.pc4   = a + 32'd4;
      return e;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset(input int n);
      rst_n = 1'b0;
      redirect_valid = 1'b0;
      repeat (n) step();
      rst_n = 1'b1;
   endtask

   task automatic chk_reset_outputs(input string tag);
      chk({tag, "_out_valid"}, 32'(out_valid), 32'd0);
      chk({tag, "_imem_req"}, 32'(imem_req), 32'd0);
      chk({tag, "_out_instr"}, out_instr, 32'h0);
      chk({tag, "_pc4"}, out_pc_plus4, 32'h0);
      chk({tag, "_opcode"}, 32'(opcode), 32'd0);
   endtask

   // Memory responder: one response per request after the chosen latency;
   // a reset abandons the pending read but still lets its late strobe arrive.
   initial begin : responder
      bit          pend_v = 1'b0;
      int          pend_cnt = 0;
      logic [31:0] pend_addr = '0;
      bit          prev_req = 1'b0;
      bit          rs;
      imem_rvalid = 1'b0;
      imem_rdata  = 32'h0;
      forever begin
         @(posedge clk);
         rs = !rst_n;
         #1;
         imem_rvalid = 1'b0;
         if (rs) begin
            if (pend_v) begin
               pend_v      = 1'b0;
               imem_rvalid = 1'b1;
               imem_rdata  = 32'hDEAD_BEEF;
            end
            prev_req = 1'b0;
         end else begin
            if (pend_v) begin
               pend_cnt--;
               if (pend_cnt == 0) begin
                  imem_rvalid = 1'b1;
                  imem_rdata  = word_at(pend_addr);
                  pend_v      = 1'b0;
               end
            end
            if (imem_req) begin
               checks++;
               if (pend_v || prev_req) begin
                  errors++;
                  $display("FAIL req_protocol: got req with outstanding=%0d back_to_back=%0d required 0 0",
                           pend_v, prev_req);
               end
               pend_v    = 1'b1;
               pend_addr = imem_addr;
               pend_cnt  = lat_rand ? int'($urandom_range(1, 4)) : lat_cfg;
            end
            prev_req = imem_req;
         end
      end
   end

   // Monitor/scoreboard: every transfer must be the next word in program order.
   initial begin : monitor
      exp_t        e;
      bit          have_prev = 1'b0;
      logic [31:0] prev_instr = '0;
      logic [31:0] prev_pc4 = '0;
      exp_q.push_back(entry_at(32'h0));
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            exp_q.delete();
            exp_q.push_back(entry_at(32'h0));
            have_prev = 1'b0;
         end else begin
            if (have_prev) begin
               checks++;
               if (!out_valid || out_instr !== prev_instr || out_pc_plus4 !== prev_pc4) begin
                  errors++;
                  $display("FAIL stable: got v=%0d instr=%h pc4=%h required v=1 instr=%h pc4=%h",
                           out_valid, out_instr, out_pc_plus4, prev_instr, prev_pc4);
               end
            end
            if (out_valid && out_ready) begin
               xfers++;
               e = exp_q.pop_front();
               $display("xfer %0d: instr=%h pc4=%h opcode=%h", xfers, out_instr, out_pc_plus4, opcode);
               chk("xfer_instr", out_instr, e.instr);
               chk("xfer_pc4", out_pc_plus4, e.pc4);
               chk("xfer_opcode", 32'(opcode), 32'(e.instr[31:26]));
               exp_q.push_back(entry_at(e.pc4));
            end
            if (redirect_valid) begin
               exp_q.delete();
               exp_q.push_back(entry_at(redirect_pc & ~32'd3));
            end
            have_prev  = out_valid && !out_ready && !redirect_valid;
            prev_instr = out_instr;
            prev_pc4   = out_pc_plus4;
         end
      end
   end

   initial begin : main
      rst_n = 1'b0;
      redirect_valid = 1'b0;
      redirect_pc = 32'h0;
      out_ready = 1'b1;

      // Reset release, L=1, decode always ready
      lat_cfg = 1;
      do_reset(3);
      chk_reset_outputs("t1_reset");
      step();
      chk("t1_req_c1", 32'(imem_req), 32'd1);
      chk("t1_addr_c1", imem_addr, 32'h0);
      chk("t1_valid_c1", 32'(out_valid), 32'd0);
      step();
      chk("t1_valid_c2", 32'(out_valid), 32'd0);
      step();
      chk("t1_valid_c3", 32'(out_valid), 32'd1);
      chk("t1_instr_c3", out_instr, 32'h2002_0005);
      chk("t1_pc4_c3", out_pc_plus4, 32'h4);
      chk("t1_opcode_c3", 32'(opcode), 32'(OP_ADDI));
      chk("t1_addr_c3", imem_addr, 32'h4);
      step();
      chk("t1_valid_c4", 32'(out_valid), 32'd0);
      step();
      chk("t1_pc4_c5", out_pc_plus4, 32'h8);
      chk("t1_addr_c5", imem_addr, 32'h8);
      repeat (2) step();
      chk("t1_pc4_c7", out_pc_plus4, 32'hC);

      // Decode stalls: second word parks in the hold buffer
      out_ready = 1'b0;
      lat_cfg = 1;
      do_reset(2);
      repeat (3) step();
      chk("t2_valid_c3", 32'(out_valid), 32'd1);
      step();
      for (int i = 0; i < 4; i++) begin
         step();
         chk("t2_hold_req", 32'(imem_req), 32'd0);
         chk("t2_hold_instr", out_instr, 32'h2002_0005);
         chk("t2_hold_pc4", out_pc_plus4, 32'h4);
      end
      out_ready = 1'b1;
      step();
      chk("t2_valid_c9", 32'(out_valid), 32'd1);
      chk("t2_instr_c9", out_instr, word_at(32'h4));
      chk("t2_pc4_c9", out_pc_plus4, 32'h8);
      chk("t2_req_c9", 32'(imem_req), 32'd1);
      chk("t2_addr_c9", imem_addr, 32'h8);

      // Redirect in WAIT, L=3, unaligned target
      lat_cfg = 3;
      do_reset(2);
      step();
      chk("t3_addr_c1", imem_addr, 32'h0);
      step();
      redirect_valid = 1'b1;
      redirect_pc = 32'h0000_0103;
      step();
      redirect_valid = 1'b0;
      chk("t3_valid_c3", 32'(out_valid), 32'd0);
      chk("t3_req_c3", 32'(imem_req), 32'd0);
      step();
      chk("t3_req_c4", 32'(imem_req), 32'd0);
      step();
      chk("t3_req_c5", 32'(imem_req), 32'd1);
      chk("t3_addr_c5", imem_addr, 32'h100);
      chk("t3_valid_c5", 32'(out_valid), 32'd0);
      for (int i = 0; i < 3; i++) begin
         step();
         chk("t3_valid_wait", 32'(out_valid), 32'd0);
      end
      step();
      chk("t3_valid_c9", 32'(out_valid), 32'd1);
      chk("t3_pc4_c9", out_pc_plus4, 32'h104);
      chk("t3_instr_c9", out_instr, word_at(32'h100));

      // Redirect coincident with the response
      lat_cfg = 2;
      do_reset(2);
      repeat (3) step();
      redirect_valid = 1'b1;
      redirect_pc = 32'h0000_0200;
      step();
      redirect_valid = 1'b0;
      chk("t4_req_c4", 32'(imem_req), 32'd1);
      chk("t4_addr_c4", imem_addr, 32'h200);
      chk("t4_valid_c4", 32'(out_valid), 32'd0);
      repeat (2) step();
      chk("t4_valid_c6", 32'(out_valid), 32'd0);
      step();
      chk("t4_valid_c7", 32'(out_valid), 32'd1);
      chk("t4_pc4_c7", out_pc_plus4, 32'h204);

      // Redirect during ISSUE to the top word; pc+4 wraps to 0
      lat_cfg = 1;
      do_reset(2);
      step();
      chk("t5_addr_c1", imem_addr, 32'h0);
      redirect_valid = 1'b1;
      redirect_pc = 32'hFFFF_FFFE;
      step();
      redirect_valid = 1'b0;
      chk("t5_req_c2", 32'(imem_req), 32'd0);
      step();
      chk("t5_req_c3", 32'(imem_req), 32'd1);
      chk("t5_addr_c3", imem_addr, 32'hFFFF_FFFC);
      chk("t5_valid_c3", 32'(out_valid), 32'd0);
      repeat (2) step();
      chk("t5_valid_c5", 32'(out_valid), 32'd1);
      chk("t5_pc4_c5", out_pc_plus4, 32'h0);
      chk("t5_instr_c5", out_instr, word_at(32'hFFFF_FFFC));
      chk("t5_addr_c5", imem_addr, 32'h0);

      // Reset in WAIT with a valid word presented; late strobe lands in IDLE
      lat_cfg = 1;
      out_ready = 1'b0;
      do_reset(2);
      repeat (2) step();
      lat_cfg = 3;
      step();
      chk("t6_valid_c3", 32'(out_valid), 32'd1);
      step();
      rst_n = 1'b0;
      step();
      rst_n = 1'b1;
      out_ready = 1'b1;
      chk_reset_outputs("t6_reset");
      step();
      chk("t6_req_c6", 32'(imem_req), 32'd1);
      chk("t6_addr_c6", imem_addr, 32'h0);
      for (int i = 0; i < 3; i++) begin
         step();
         chk("t6_valid_wait", 32'(out_valid), 32'd0);
      end
      step();
      chk("t6_valid_c10", 32'(out_valid), 32'd1);
      chk("t6_pc4_c10", out_pc_plus4, 32'h4);
      chk("t6_instr_c10", out_instr, 32'h2002_0005);

      // Random phase: random latency, back-pressure and redirects
      lat_rand = 1'b1;
      out_ready = 1'b1;
      do_reset(2);
      xfers = 0;
      repeat (3000) begin
         step();
         out_ready = ($urandom_range(0, 99) < 70);
         redirect_valid = ($urandom_range(0, 99) < 4);
         if ($urandom_range(0, 3) == 0)
            redirect_pc = 32'hFFFF_FFF0 | 32'($urandom_range(0, 15));
         else
            redirect_pc = $urandom;
      end
      redirect_valid = 1'b0;
      step();
      chk("rand_progress", 32'(xfers > 150), 32'd1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
